// File: rtl/ysyx_exu_mc.sv
// Multi-cycle execute unit: register file, single-cycle ALU and an iterative
// shift-add multiplier behind a valid/ready handshake on both sides.
module ysyx_exu_mc #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int MUL_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_rf_wr_en,
  input  logic            in_rf_wr_sel,
  input  logic            in_alu_a_sel,
  input  logic            in_alu_b_sel,
  input  logic [3:0]      in_alu_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_wdata,
  output logic [XLEN-1:0] jump_addr
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int SW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic            wr_en_q, wr_en_d;
  logic            wr_sel_q, wr_sel_d;
  logic            a_sel_q, a_sel_d;

  logic [RW-1:0]   rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] rs1_val, rs2_val, op_a, op_b, alu_res;
  logic [SW-1:0]   shamt;
  logic            is_mul;
  logic            unused_inst_bits;

  assign unused_inst_bits = ^{in_inst[6:0], in_inst[14:12], in_inst[31:25]};

  assign rs1_idx = in_inst[15 +: RW];
  assign rs2_idx = in_inst[20 +: RW];
  assign rd_idx  = in_inst[7 +: RW];

  always_comb begin
    rs1_val = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
    rs2_val = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];
    op_a    = in_alu_a_sel ? rs1_val : in_pc;
    op_b    = in_alu_b_sel ? in_imm : rs2_val;
    shamt   = op_b[SW-1:0];
    is_mul  = (MUL_EN != 0) && (in_alu_ctrl == 4'd11);
  end

  // ctrl 11 lands in the default (ADD) arm; with the multiplier enabled it
  // never reaches this result because it is routed to BUSY instead.
  always_comb begin
    alu_res = op_a + op_b;
    unique case (in_alu_ctrl)
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a << shamt;
      4'd3:    alu_res = XLEN'($signed(op_a) < $signed(op_b));
      4'd4:    alu_res = XLEN'(op_a < op_b);
      4'd5:    alu_res = op_a ^ op_b;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = XLEN'($signed(op_a) >>> shamt);
      4'd8:    alu_res = op_a | op_b;
      4'd9:    alu_res = op_a & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = op_a + op_b;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rf_d     = rf_q;
    res_d    = res_q;
    pc4_d    = pc4_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_en_d  = wr_en_q;
    wr_sel_d = wr_sel_q;
    a_sel_d  = a_sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pc4_d    = in_pc + XLEN'(4);
          rd_d     = rd_idx;
          wr_en_d  = in_rf_wr_en;
          wr_sel_d = in_rf_wr_sel;
          a_sel_d  = in_alu_a_sel;
          if (is_mul) begin
            res_d    = '0;
            mcand_d  = op_a;
            mplier_d = op_b;
            cnt_d    = '0;
            state_d  = S_BUSY;
          end else begin
            res_d    = alu_res;
            state_d  = S_DONE;
          end
        end
      end
      S_BUSY: begin
        // res_q doubles as the product accumulator; one multiplier bit per cycle
        if (mplier_q[0]) res_d = res_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SW'(1);
        if (cnt_q == SW'(XLEN - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          if (wr_en_q && (rd_q != '0)) rf_d[rd_q] = wr_sel_q ? pc4_q : res_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
      res_q    <= '0;
      pc4_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_en_q  <= 1'b0;
      wr_sel_q <= 1'b0;
      a_sel_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rf_q     <= rf_d;
      res_q    <= res_d;
      pc4_q    <= pc4_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_en_q  <= wr_en_d;
      wr_sel_q <= wr_sel_d;
      a_sel_q  <= a_sel_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_wdata = wr_sel_q ? pc4_q : res_q;
  assign jump_addr = a_sel_q ? {res_q[XLEN-1:1], 1'b0} : res_q;

endmodule

// File: tb/tb_ysyx_exu_mc.sv
// Directed bench for ysyx_exu_mc: ALU/MUL vector table plus handshake,
// stall, x0 and reset-abort sequences.
module tb_ysyx_exu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_inst, in_pc, in_imm;
  logic        in_rf_wr_en, in_rf_wr_sel, in_alu_a_sel, in_alu_b_sel;
  logic [3:0]  in_alu_ctrl;
  logic        out_valid, out_ready;
  logic [31:0] out_wdata, jump_addr;

  int total = 0;
  int bad   = 0;

  ysyx_exu_mc #(.XLEN(32), .NREG(32), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_imm(in_imm),
    .in_rf_wr_en(in_rf_wr_en), .in_rf_wr_sel(in_rf_wr_sel),
    .in_alu_a_sel(in_alu_a_sel), .in_alu_b_sel(in_alu_b_sel),
    .in_alu_ctrl(in_alu_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wdata(out_wdata), .jump_addr(jump_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] mk_inst(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, 7'b0110011};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one instruction from IDLE with out_ready=1; returns result, cycles
  // until out_valid, and cycles in_ready was low over that window.
  task automatic exec(input logic [3:0] ctrl, input logic a_sel, b_sel, wr_en, wr_sel,
                      input logic [4:0] rd, rs1, rs2, input logic [31:0] pc, imm,
                      output logic [31:0] wd, ja, output int lat, output int nr);
    in_inst = mk_inst(rd, rs1, rs2);
    in_alu_ctrl = ctrl; in_alu_a_sel = a_sel; in_alu_b_sel = b_sel;
    in_rf_wr_en = wr_en; in_rf_wr_sel = wr_sel; in_pc = pc; in_imm = imm;
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_inst = '0; in_imm = '0; in_pc = '0;
    lat = 1;
    nr = in_ready ? 0 : 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!in_ready) nr++;
    end
    wd = out_wdata; ja = jump_addr;
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL exec_timeout: got no out_valid expected out_valid within 100 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic setreg(input logic [4:0] r, input logic [31:0] v);
    logic [31:0] wd, ja; int lat, nr;
    exec(4'd10, 1'b1, 1'b1, 1'b1, 1'b0, r, 5'd0, 5'd0, 32'h0, v, wd, ja, lat, nr);
  endtask

  task automatic readreg(input logic [4:0] r, output logic [31:0] v);
    logic [31:0] ja; int lat, nr;
    exec(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, r, 5'd0, 32'h0, 32'h0, v, ja, lat, nr);
  endtask

  initial begin
    vec_t        vecs [18];
    logic [31:0] wd, ja, rv;
    int          lat, nr;
    logic        ok;

    vecs = '{
      '{4'd0,  32'd7,         32'd5,         32'd12},
      '{4'd0,  32'hFFFFFFFF,  32'd1,         32'd0},
      '{4'd1,  32'd5,         32'd7,         32'hFFFFFFFE},
      '{4'd2,  32'd1,         32'd33,        32'd2},
      '{4'd3,  32'hFFFFFFFF,  32'd1,         32'd1},
      '{4'd4,  32'hFFFFFFFF,  32'd1,         32'd0},
      '{4'd5,  32'hF0F0F0F0,  32'hFF00FF00,  32'h0FF00FF0},
      '{4'd6,  32'h80000000,  32'd4,         32'h08000000},
      '{4'd7,  32'h80000000,  32'd4,         32'hF8000000},
      '{4'd8,  32'h0F0F0000,  32'h000000F0,  32'h0F0F00F0},
      '{4'd9,  32'h12345678,  32'h0000FFFF,  32'h00005678},
      '{4'd10, 32'h11111111,  32'hDEADBEEF,  32'hDEADBEEF},
      '{4'd11, 32'd7,         32'd6,         32'd42},
      '{4'd11, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFE},
      '{4'd11, 32'h00010000,  32'h00010000,  32'h00000000},
      '{4'd11, 32'h00012345,  32'h00000100,  32'h01234500},
      '{4'd12, 32'd3,         32'd4,         32'd7},
      '{4'd15, 32'd10,        32'd20,        32'd30}
    };

    in_valid = 1'b0; out_ready = 1'b1; in_inst = '0; in_pc = '0; in_imm = '0;
    in_rf_wr_en = 1'b0; in_rf_wr_sel = 1'b0; in_alu_a_sel = 1'b0;
    in_alu_b_sel = 1'b0; in_alu_ctrl = '0;

    rst_n = 1'b0;
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_wdata", out_wdata, 32'd0);
    check("rst_jump_addr", jump_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // ADDI x1,x0,5
    exec(4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0, 32'd5, wd, ja, lat, nr);
    check("addi_wdata", wd, 32'd5);
    check("addi_latency", lat, 32'd1);
    readreg(5'd1, rv);
    check("addi_x1", rv, 32'd5);

    foreach (vecs[i]) begin
      setreg(5'd1, vecs[i].a);
      setreg(5'd2, vecs[i].b);
      exec(vecs[i].op, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h0, wd, ja, lat, nr);
      check($sformatf("vec%0d_op%0d_wdata", i, vecs[i].op), wd, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, (vecs[i].op == 4'd11) ? 32'd33 : 32'd1);
      check($sformatf("vec%0d_notready", i), nr, (vecs[i].op == 4'd11) ? 32'd33 : 32'd1);
      readreg(5'd3, rv);
      check($sformatf("vec%0d_x3", i), rv, vecs[i].exp);
    end

    // JALR x5,x1,3
    setreg(5'd1, 32'h80000000);
    exec(4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 5'd0, 32'h80000010, 32'd3, wd, ja, lat, nr);
    check("jalr_jump_addr", ja, 32'h80000002);
    check("jalr_wdata", wd, 32'h80000014);
    readreg(5'd5, rv);
    check("jalr_x5", rv, 32'h80000014);

    // pc-relative target keeps bit0
    exec(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h00000101, 32'h0, wd, ja, lat, nr);
    check("pcrel_jump_addr", ja, 32'h00000101);

    // write to x0 discarded
    exec(4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'd9, wd, ja, lat, nr);
    check("x0_write_wdata", wd, 32'd9);
    readreg(5'd0, rv);
    check("x0_read", rv, 32'd0);

    // stall in DONE for 10 cycles with in_valid pulses
    setreg(5'd1, 32'd11);
    in_inst = mk_inst(5'd6, 5'd1, 5'd0);
    in_alu_ctrl = 4'd0; in_alu_a_sel = 1'b1; in_alu_b_sel = 1'b1;
    in_rf_wr_en = 1'b1; in_rf_wr_sel = 1'b0; in_imm = 32'd4; in_pc = '0;
    out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_inst = mk_inst(5'd6, 5'd0, 5'd0); in_imm = 32'd100;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_wdata !== 32'd15 || in_ready !== 1'b0) ok = 1'b0;
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
    end
    check("stall_stable", {31'b0, ok}, 32'd1);
    check("stall_wdata_end", out_wdata, 32'd15);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_valid", {31'b0, out_valid}, 32'd0);
    check("stall_release_ready", {31'b0, in_ready}, 32'd1);
    readreg(5'd6, rv);
    check("stall_x6", rv, 32'd15);

    // reset during MUL at BUSY cycle 10
    setreg(5'd1, 32'd7);
    setreg(5'd2, 32'd6);
    setreg(5'd3, 32'h33);
    in_inst = mk_inst(5'd3, 5'd1, 5'd2);
    in_alu_ctrl = 4'd11; in_alu_a_sel = 1'b1; in_alu_b_sel = 1'b0;
    in_rf_wr_en = 1'b1; in_rf_wr_sel = 1'b0; in_imm = '0; in_pc = '0;
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("mul_busy_ready", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_wdata", out_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_post_ready", {31'b0, in_ready}, 32'd1);
    readreg(5'd3, rv);
    check("abort_x3", rv, 32'd0);
    readreg(5'd1, rv);
    check("abort_x1", rv, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
